// File: rtl/reduce_pkg.sv
// Shared types and constants for the reduction-engine arbiter.
package reduce_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        WAIT   = 2'd3
    } state_t;

    // Requester-ID width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reduce_arbiter_if.sv
// Requester, engine and result signals of the reduction arbiter.
interface reduce_arbiter_if import reduce_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      eng_rst;
    logic [DATA_W-1:0]         eng_in_data;
    logic                      eng_in_valid;
    logic [DATA_W-1:0]         eng_out_data;
    logic                      eng_out_valid;
    logic [DATA_W-1:0]         res_data;
    logic                      res_valid;
    logic [ID_W-1:0]           res_id;
    logic                      err;

    // Environment side: requesters plus the reduction engine.
    modport master (
        output req, req_data, req_valid, eng_out_data, eng_out_valid,
        input  req_ready, grant, eng_rst, eng_in_data, eng_in_valid,
        input  res_data, res_valid, res_id, err
    );

    modport slave (
        input  req, req_data, req_valid, eng_out_data, eng_out_valid,
        output req_ready, grant, eng_rst, eng_in_data, eng_in_valid,
        output res_data, res_valid, res_id, err
    );
endinterface

// File: rtl/rr_picker.sv
// Round-robin priority encoder: first set req bit at or after rr_ptr, wrapping.
module rr_picker import reduce_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_idx,
    output logic               any
);
    int k;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        k        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (!any && req[k]) begin
                pick[k]  = 1'b1;
                pick_idx = ID_W'(k);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reduce_arbiter.sv
// Shares one streaming reduction engine among NUM_REQ requesters, one frame
// at a time, with round-robin fairness and an engine-result timeout.
module reduce_arbiter import reduce_pkg::*; #(
    parameter int NUM_REQ   = 4,
    parameter int FRAME_LEN = 512,
    parameter int TIMEOUT   = 64,
    parameter int ID_W      = id_width(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    reduce_arbiter_if.slave  bus
);
    localparam int WC_W = $clog2(FRAME_LEN + 1);
    localparam int TC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] FRAME_CNT = WC_W'(FRAME_LEN);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_LEN - 1);
    localparam logic [TC_W-1:0] TC_LIMIT  = TC_W'(TIMEOUT);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, owner, pick_idx;
    logic [NUM_REQ-1:0]  pick, grant_q, ready;
    logic                any;
    logic [WC_W-1:0]     wcnt;
    logic [TC_W-1:0]     tcnt, tcnt_inc;
    logic                accept, last_word, timeout, frame_done, eng_clr;
    logic [DATA_W-1:0]   data_p1, res_data_q;
    logic                vld_p1, res_vld_q, err_q;
    logic [ID_W-1:0]     res_id_q;

    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .req      (bus.req),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = CLEAR;
            CLEAR:   state_nxt = STREAM;
            STREAM:  if (accept && last_word) state_nxt = WAIT;
            WAIT:    if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A result on the same cycle the timeout count lands still wins.
    always_comb begin
        ready      = '0;
        accept     = 1'b0;
        eng_clr    = !rst_n;
        tcnt_inc   = tcnt + 1'b1;
        timeout    = (tcnt_inc == TC_LIMIT);
        last_word  = (wcnt == LAST_WORD);
        frame_done = 1'b0;
        case (state)
            CLEAR:  eng_clr = 1'b1;
            STREAM: begin
                if (wcnt < FRAME_CNT) begin
                    ready[owner] = 1'b1;
                    accept       = bus.req_valid[owner];
                end
            end
            WAIT:   frame_done = bus.eng_out_valid || timeout;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            owner      <= '0;
            grant_q    <= '0;
            wcnt       <= '0;
            tcnt       <= '0;
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            // stage p1: accepted word registered toward the engine
            vld_p1    <= accept;
            res_vld_q <= 1'b0;
            err_q     <= 1'b0;
            if (accept) begin
                data_p1 <= bus.req_data[int'(owner)*DATA_W +: DATA_W];
                wcnt    <= wcnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (any) begin
                        owner   <= pick_idx;
                        grant_q <= pick;
                    end
                end
                CLEAR: begin
                    wcnt <= '0;
                    tcnt <= '0;
                end
                WAIT: begin
                    tcnt <= tcnt_inc;
                    if (bus.eng_out_valid) begin
                        res_vld_q  <= 1'b1;
                        res_data_q <= bus.eng_out_data;
                        res_id_q   <= owner;
                    end else if (timeout) begin
                        err_q    <= 1'b1;
                        res_id_q <= owner;
                    end
                    if (frame_done) begin
                        grant_q <= '0;
                        rr_ptr  <= (owner == LAST_ID) ? '0 : owner + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = ready;
    assign bus.grant        = grant_q;
    assign bus.eng_rst      = eng_clr;
    assign bus.eng_in_data  = data_p1;
    assign bus.eng_in_valid = vld_p1;
    assign bus.res_data     = res_data_q;
    assign bus.res_valid    = res_vld_q;
    assign bus.res_id       = res_id_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_reduce_arbiter.sv
// Scoreboard bench for reduce_arbiter with a behavioural summing engine.
module tb_reduce_arbiter;
    import reduce_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int FRAME_LEN = 4;
    localparam int TIMEOUT   = 8;
    localparam int ID_W      = 2;

    typedef struct packed {
        logic            is_err;
        logic [ID_W-1:0] id;
        logic [31:0]     sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reduce_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    reduce_arbiter #(
        .NUM_REQ(NUM_REQ), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   cnt_rst = 0;
    int   cnt_inv = 0;
    int   viol = 0;
    exp_t sb[$];
    exp_t mon_e;
    bit   sticky = 1'b0;
    bit   dead = 1'b0;

    // Engine: sums a frame and presents the total 2 cycles after the last word.
    logic [31:0] acc, eo_d;
    logic        eo_v;
    int          ecnt, dly;

    assign bus.eng_out_valid = eo_v;
    assign bus.eng_out_data  = eo_d;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.eng_rst) begin
            acc <= '0; eo_d <= '0; eo_v <= 1'b0; ecnt <= 0; dly <= 0;
        end else begin
            if (!sticky) eo_v <= 1'b0;
            if (bus.eng_in_valid) begin
                acc  <= acc + bus.eng_in_data;
                ecnt <= ecnt + 1;
                if (ecnt == FRAME_LEN - 1) dly <= 2;
            end
            if (dly == 1 && !dead) begin
                eo_v <= 1'b1;
                eo_d <= acc;
            end
            if (dly != 0) dly <= dly - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.eng_rst) cnt_rst++;
            if (bus.eng_in_valid) cnt_inv++;
            if (((bus.req_ready & ~bus.grant) != '0) || !$onehot0(bus.grant)) viol++;
            if (bus.res_valid || bus.err) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", {bus.res_valid, bus.err}, 2'b00);
                end else begin
                    mon_e = sb.pop_front();
                    check("res_id", bus.res_id, mon_e.id);
                    check("err_flag", bus.err, mon_e.is_err);
                    check("res_valid_flag", bus.res_valid, !mon_e.is_err);
                    if (mon_e.is_err) check("err_latency", cyc - last_acc, TIMEOUT);
                    else              check("res_data", bus.res_data, mon_e.sum);
                end
            end
        end
    end

    task automatic check_reset_state();
        check("rst_grant", bus.grant, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_eng_in_valid", bus.eng_in_valid, 0);
        check("rst_eng_in_data", bus.eng_in_data, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_err", bus.err, 0);
        check("rst_eng_rst", bus.eng_rst, 1);
    endtask

    task automatic wait_grant(output int id);
        id = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.grant != '0) break;
            @(negedge clk);
        end
        check("grant_seen", bus.grant != '0, 1'b1);
        for (int k = 0; k < NUM_REQ; k++) if (bus.grant[k]) id = k;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (bus.grant == '0) break;
            @(negedge clk);
        end
        check("grant_release", bus.grant == '0, 1'b1);
    endtask

    task automatic drain();
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drain", sb.size(), 0);
    endtask

    // Feeds n words base+step*i; pushes the expectation once a full frame is in.
    task automatic feed(input int id, input logic [31:0] base, input logic [31:0] step,
                        input int n, input int stall_at, input bit drop);
        logic [31:0] w, sum;
        logic        got;
        exp_t        e;
        sum = '0;
        if (id < 0) return;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                bus.req_valid[id] = 1'b0;
                if (drop) bus.req[id] = 1'b0;
                repeat (3) @(negedge clk);
            end
            w = base + step * i;
            bus.req_data[id*32 +: 32] = w;
            bus.req_valid[id] = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                got = bus.req_ready[id];
                @(negedge clk);
            end
            if (!got) begin
                check("word_accept", got, 1'b1);
                bus.req_valid[id] = 1'b0;
                return;
            end
            sum = sum + w;
            if (i == FRAME_LEN - 1) begin
                last_acc = cyc;
                e.is_err = dead;
                e.id     = ID_W'(id);
                e.sum    = sum;
                sb.push_back(e);
            end
        end
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        bus.req = '0;
        bus.req_valid = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_eng_rst", bus.eng_rst, 0);
        cnt_rst = 0;
        cnt_inv = 0;

        // single request
        bus.req = 4'b0001;
        wait_grant(id);
        check("t1_id", id, 0);
        bus.req = '0;
        feed(id, 1, 1, FRAME_LEN, -1, 1'b0);
        wait_idle();
        drain();
        check("t1_eng_rst_pulses", cnt_rst, 1);
        check("t1_eng_in_valids", cnt_inv, FRAME_LEN);
        check("t1_grant_after", bus.grant, 0);

        // contention, starting from a fresh rr_ptr
        do_reset();
        bus.req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_grant(id);
            check("t2_order", id, f % NUM_REQ);
            if (f == 4) bus.req = '0;
            feed(id, 5, 0, FRAME_LEN, -1, 1'b0);
            wait_idle();
        end
        drain();

        // stall with req dropped mid-frame; requester 3 waits meanwhile
        bus.req = 4'b1010;
        wait_grant(id);
        check("t3_id", id, 1);
        feed(id, 10, 1, FRAME_LEN, 2, 1'b1);
        wait_idle();
        wait_grant(id);
        check("t3_next_id", id, 3);
        bus.req = '0;
        feed(id, 2, 0, FRAME_LEN, -1, 1'b0);
        wait_idle();
        drain();

        // engine timeout, then normal service
        dead = 1'b1;
        bus.req = 4'b1000;
        wait_grant(id);
        check("t4_id", id, 3);
        bus.req = '0;
        feed(id, 7, 0, FRAME_LEN, -1, 1'b0);
        wait_idle();
        drain();
        dead = 1'b0;
        bus.req = 4'b0100;
        wait_grant(id);
        check("t4_after_id", id, 2);
        bus.req = '0;
        feed(id, 3, 3, FRAME_LEN, -1, 1'b0);
        wait_idle();
        drain();

        // sticky engine result level
        sticky = 1'b1;
        bus.req = 4'b0010;
        wait_grant(id);
        check("t5_first_id", id, 1);
        bus.req = '0;
        feed(id, 1, 2, FRAME_LEN, -1, 1'b0);
        wait_idle();
        drain();
        repeat (3) @(negedge clk);
        check("t5_level_held", bus.eng_out_valid, 1);
        check("t5_no_res_idle", bus.res_valid, 0);
        bus.req = 4'b0100;
        wait_grant(id);
        check("t5_second_id", id, 2);
        bus.req = '0;
        feed(id, 100, 1, FRAME_LEN, -1, 1'b0);
        wait_idle();
        drain();
        repeat (3) @(negedge clk);
        sticky = 1'b0;

        // reset in the middle of a frame
        bus.req = 4'b0010;
        wait_grant(id);
        check("t6_id", id, 1);
        feed(id, 9, 1, 2, -1, 1'b0);
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_valid = '0;
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        @(negedge clk);
        bus.req = 4'b0100;
        @(negedge clk);
        check("t6_regrant", bus.grant, 4'b0100);
        check("t6_clear", bus.eng_rst, 1);
        bus.req = '0;
        feed(2, 4, 4, FRAME_LEN, -1, 1'b0);
        wait_idle();
        drain();

        check("ready_exclusive", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
